// File: rtl/lsu_controller.sv
// Load/store unit controller: checks alignment, issues one word-aligned memory access per
// request, and returns the sign- or zero-extended load result through a registered output.
module lsu_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_req,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_size,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic [31:0] lsu_rdata,
   output logic        lsu_stall,
   output logic        lsu_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [2:0] SizeByte  = 3'd0;
   localparam logic [2:0] SizeHalf  = 3'd1;
   localparam logic [2:0] SizeWord  = 3'd2;
   localparam logic [2:0] SizeUByte = 3'd4;
   localparam logic [2:0] SizeUHalf = 3'd5;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  size_q, size_d;
   logic        we_q, we_d;

   logic        req_fault;
   logic [3:0]  be_lane;
   logic [31:0] wdata_lane;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   always_comb begin
      req_fault = 1'b0;
      case (lsu_size)
         SizeByte, SizeUByte: req_fault = 1'b0;
         SizeHalf, SizeUHalf: req_fault = lsu_addr[0];
         SizeWord:            req_fault = |lsu_addr[1:0];
         default:             req_fault = 1'b1;
      endcase
   end

   // Byte enables and replicated store data come only from the latched request.
   always_comb begin
      be_lane    = 4'b0000;
      wdata_lane = wdata_q;
      case (size_q)
         SizeByte, SizeUByte: begin
            be_lane    = 4'b0001 << addr_q[1:0];
            wdata_lane = {4{wdata_q[7:0]}};
         end
         SizeHalf, SizeUHalf: begin
            be_lane    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata_q[15:0]}};
         end
         SizeWord: begin
            be_lane    = 4'b1111;
            wdata_lane = wdata_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         SizeByte:  load_data = {{24{byte_lane[7]}}, byte_lane};
         SizeUByte: load_data = {24'h000000, byte_lane};
         SizeHalf:  load_data = {{16{half_lane[15]}}, half_lane};
         SizeUHalf: load_data = {16'h0000, half_lane};
         default:   load_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      we_d      = we_q;
      rdata_d   = rdata_q;
      lsu_stall = 1'b0;
      lsu_fault = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      case (state_q)
         StIdle: begin
            if (lsu_req) begin
               if (req_fault) begin
                  lsu_fault = 1'b1;
               end else begin
                  lsu_stall = 1'b1;
                  addr_d    = lsu_addr;
                  wdata_d   = lsu_wdata;
                  size_d    = lsu_size;
                  we_d      = lsu_we;
                  state_d   = StBusy;
               end
            end
         end
         StBusy: begin
            mem_req   = 1'b1;
            lsu_stall = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_we    = we_q;
            mem_be    = be_lane;
            mem_wdata = wdata_lane;
            if (mem_ready) begin
               state_d = StDone;
               if (!we_q) begin
                  rdata_d = load_data;
               end
            end
         end
         // lsu_req here still belongs to the retiring instruction.
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         size_q  <= 3'd0;
         we_q    <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   assign lsu_rdata = rdata_q;

endmodule
